// File: rtl/snitch_icache_refill.sv
// Icache line refill responder: takes one line request, fetches the line as
// NUM_BEATS narrow pipelined reads and returns the assembled line with a
// sticky error flag and the original refill ID.
//
// state | meaning
// IDLE  | waiting for a refill request, req_ready high
// FETCH | issuing beat reads and collecting beat responses
// RESP  | full line held on the response port until accepted
module snitch_icache_refill #(
  parameter int unsigned FETCH_AW   = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned MEM_DW     = 32,
  parameter int unsigned PENDING_IW = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [FETCH_AW-1:0]   refill_req_addr_i,
  input  logic [PENDING_IW-1:0] refill_req_id_i,
  input  logic                  refill_req_valid_i,
  output logic                  refill_req_ready_o,
  output logic [LINE_WIDTH-1:0] refill_rsp_data_o,
  output logic                  refill_rsp_error_o,
  output logic [PENDING_IW-1:0] refill_rsp_id_o,
  output logic                  refill_rsp_valid_o,
  input  logic                  refill_rsp_ready_i,
  output logic [FETCH_AW-1:0]   mem_req_addr_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  input  logic [MEM_DW-1:0]     mem_rsp_data_i,
  input  logic                  mem_rsp_error_i,
  input  logic                  mem_rsp_valid_i,
  output logic                  mem_rsp_ready_o
);

  localparam int unsigned NUM_BEATS  = LINE_WIDTH / MEM_DW;
  localparam int unsigned LINE_ALIGN = $clog2(LINE_WIDTH / 8);
  localparam int unsigned BEAT_ALIGN = $clog2(MEM_DW / 8);
  localparam int unsigned CW         = $clog2(NUM_BEATS) + 1;

  localparam logic [FETCH_AW-1:0] LINE_MASK =
    ~((FETCH_AW'(1) << LINE_ALIGN) - FETCH_AW'(1));
  localparam logic [CW-1:0] BEATS     = CW'(NUM_BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [FETCH_AW-1:0]     base_q;
  logic [PENDING_IW-1:0]   id_q;
  logic [CW-1:0]           issue_cnt_q;
  logic [CW-1:0]           recv_cnt_q;
  logic [LINE_WIDTH-1:0]   line_q;
  logic                    error_q;

  // Next state and handshake outputs; everything defaults to inactive.
  always_comb begin
    state_d            = state_q;
    refill_req_ready_o = 1'b0;
    refill_rsp_valid_o = 1'b0;
    mem_req_valid_o    = 1'b0;
    mem_rsp_ready_o    = 1'b0;
    case (state_q)
      IDLE: begin
        refill_req_ready_o = 1'b1;
        if (refill_req_valid_i) state_d = FETCH;
      end
      FETCH: begin
        mem_req_valid_o = (issue_cnt_q < BEATS);
        mem_rsp_ready_o = 1'b1;
        if (mem_rsp_valid_i && (recv_cnt_q == LAST_BEAT)) state_d = RESP;
      end
      RESP: begin
        refill_rsp_valid_o = 1'b1;
        if (refill_rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat offset lands in the zeroed low bits of the base, so OR never carries.
  assign mem_req_addr_o     = base_q | (FETCH_AW'(issue_cnt_q) << BEAT_ALIGN);
  assign refill_rsp_data_o  = line_q;
  assign refill_rsp_error_o = error_q;
  assign refill_rsp_id_o    = id_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Request capture, beat issue/receive counters and line assembly.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      base_q      <= '0;
      id_q        <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      line_q      <= '0;
      error_q     <= 1'b0;
    end else begin
      if (refill_req_ready_o && refill_req_valid_i) begin
        base_q      <= refill_req_addr_i & LINE_MASK;
        id_q        <= refill_req_id_i;
        issue_cnt_q <= '0;
        recv_cnt_q  <= '0;
        error_q     <= 1'b0;
      end
      if (mem_req_valid_o && mem_req_ready_i) begin
        issue_cnt_q <= issue_cnt_q + CW'(1);
      end
      if (mem_rsp_ready_o && mem_rsp_valid_i) begin
        for (int b = 0; b < NUM_BEATS; b++) begin
          if (recv_cnt_q == CW'(b)) line_q[b*MEM_DW +: MEM_DW] <= mem_rsp_data_i;
        end
        error_q    <= error_q | mem_rsp_error_i;
        recv_cnt_q <= recv_cnt_q + CW'(1);
      end
    end
  end

  // A beat response while not fetching means the memory side broke protocol.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rsp_valid_i |-> (state_q == FETCH));

endmodule

// File: tb/tb_snitch_icache_refill.sv
// Bench for snitch_icache_refill: a 128/32 instance driven by a queue-based
// memory and refill model, plus a 64/64 instance for the single-beat case.
module tb_snitch_icache_refill;

  localparam int AW = 32, LW = 128, DW = 32, IW = 2, NB = LW / DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [AW-1:0] req_addr;   logic [IW-1:0] req_id;   logic req_valid, req_ready;
  logic [LW-1:0] rsp_data;   logic rsp_error;         logic [IW-1:0] rsp_id;
  logic rsp_valid, rsp_ready;
  logic [AW-1:0] mreq_addr;  logic mreq_valid, mreq_ready;
  logic [DW-1:0] mrsp_data;  logic mrsp_error, mrsp_valid, mrsp_ready;

  logic [AW-1:0] s_addr;     logic [IW-1:0] s_id;     logic s_valid, s_ready;
  logic [63:0]   s_rdata;    logic s_rerror;          logic [IW-1:0] s_rid;
  logic s_rvalid, s_rready;
  logic [AW-1:0] s_maddr;    logic s_mvalid, s_mready;
  logic [63:0]   s_mdata;    logic s_merror, s_mrvalid, s_mrready;

  snitch_icache_refill #(.FETCH_AW(AW), .LINE_WIDTH(LW), .MEM_DW(DW), .PENDING_IW(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .refill_req_addr_i(req_addr), .refill_req_id_i(req_id),
    .refill_req_valid_i(req_valid), .refill_req_ready_o(req_ready),
    .refill_rsp_data_o(rsp_data), .refill_rsp_error_o(rsp_error),
    .refill_rsp_id_o(rsp_id), .refill_rsp_valid_o(rsp_valid), .refill_rsp_ready_i(rsp_ready),
    .mem_req_addr_o(mreq_addr), .mem_req_valid_o(mreq_valid), .mem_req_ready_i(mreq_ready),
    .mem_rsp_data_i(mrsp_data), .mem_rsp_error_i(mrsp_error),
    .mem_rsp_valid_i(mrsp_valid), .mem_rsp_ready_o(mrsp_ready));

  snitch_icache_refill #(.FETCH_AW(AW), .LINE_WIDTH(64), .MEM_DW(64), .PENDING_IW(IW)) dut1b (
    .clk_i(clk), .rst_ni(rst_n),
    .refill_req_addr_i(s_addr), .refill_req_id_i(s_id),
    .refill_req_valid_i(s_valid), .refill_req_ready_o(s_ready),
    .refill_rsp_data_o(s_rdata), .refill_rsp_error_o(s_rerror),
    .refill_rsp_id_o(s_rid), .refill_rsp_valid_o(s_rvalid), .refill_rsp_ready_i(s_rready),
    .mem_req_addr_o(s_maddr), .mem_req_valid_o(s_mvalid), .mem_req_ready_i(s_mready),
    .mem_rsp_data_i(s_mdata), .mem_rsp_error_i(s_merror),
    .mem_rsp_valid_i(s_mrvalid), .mem_rsp_ready_o(s_mrready));

  typedef struct { logic [AW-1:0] addr; logic [IW-1:0] id; logic [NB-1:0] emask; } req_t;
  typedef struct { logic [AW-1:0] base; logic [IW-1:0] id; logic [NB-1:0] emask;
                   logic [LW-1:0] line; logic err; int t_acc; } refill_t;
  typedef struct { logic [AW-1:0] addr; logic err; } beat_t;

  req_t    send_q[$];
  refill_t exp_q[$];
  beat_t   mem_q[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, issued = 0, recv = 0, bp_ph = 0, bp_mode = 0, stall_left = 0;
  bit rand_mode = 0, lat_check = 0, seen_v = 0, hold = 0;
  logic [LW-1:0] held_data; logic [IW-1:0] held_id; logic held_err;
  logic [31:0] salt;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Expected refill: every beat of the aligned line, beat 0 in the low word.
  function automatic refill_t predict(input req_t r, input int t);
    refill_t e;
    e.base  = {r.addr[AW-1:4], 4'h0};
    e.id    = r.id;
    e.emask = r.emask;
    e.err   = |r.emask;
    e.t_acc = t;
    e.line  = '0;
    for (int b = 0; b < NB; b++) e.line[b*DW +: DW] = mem_word(e.base + 32'(b * (DW / 8)));
    return e;
  endfunction

  task automatic drive();
    bp_ph++;
    req_valid = (send_q.size() > 0);
    req_addr  = req_valid ? send_q[0].addr : '0;
    req_id    = req_valid ? send_q[0].id : '0;
    case (bp_mode)
      0:       mreq_ready = 1'b1;
      1:       mreq_ready = (bp_ph % 3 == 0);
      default: mreq_ready = 1'($urandom_range(0, 1));
    endcase
    mrsp_valid = (mem_q.size() > 0);
    mrsp_data  = mrsp_valid ? mem_word(mem_q[0].addr) : '0;
    mrsp_error = mrsp_valid ? mem_q[0].err : 1'b0;
    rsp_ready  = (stall_left == 0);
  endtask

  task automatic cycle();
    bit push_m, pop_m;
    beat_t nb;
    logic rv, rr;
    push_m = 0; pop_m = 0;
    nb.addr = '0; nb.err = 1'b0;
    @(negedge clk);
    cyc++;
    rv = rsp_valid; rr = rsp_ready;
    chk("req_ready", req_ready, exp_q.size() == 0);
    if (exp_q.size() == 0) chk("spurious_rsp_valid", rv, 1'b0);
    if (hold) begin
      chk("stall_valid", rv, 1'b1);
      chk("stall_data", rsp_data, held_data);
      chk("stall_id", rsp_id, held_id);
      chk("stall_err", rsp_error, held_err);
    end
    hold = rv && !rr; held_data = rsp_data; held_id = rsp_id; held_err = rsp_error;
    if (exp_q.size() > 0 && rv && !seen_v) begin
      seen_v = 1;
      if (lat_check) chk("rsp_latency", cyc - exp_q[0].t_acc, NB + 2);
    end
    if (mreq_valid && mreq_ready) begin
      if (exp_q.size() == 0) chk("mreq_when_idle", mreq_valid, 1'b0);
      else begin
        chk("mreq_addr", mreq_addr, exp_q[0].base + 32'(issued * (DW / 8)));
        chk("mreq_no_extra", issued < NB, 1'b1);
        nb.addr = mreq_addr;
        nb.err  = exp_q[0].emask[mreq_addr[3:2]];
        push_m  = 1;
        issued++;
      end
    end
    if (mrsp_valid && mrsp_ready) begin pop_m = 1; recv++; end
    if (rv && rr && exp_q.size() > 0) begin
      chk("rsp_data", rsp_data, exp_q[0].line);
      chk("rsp_error", rsp_error, exp_q[0].err);
      chk("rsp_id", rsp_id, exp_q[0].id);
      chk("beats_issued", issued, NB);
      void'(exp_q.pop_front());
      issued = 0; recv = 0; seen_v = 0;
      if (rand_mode) stall_left = $urandom_range(0, 3);
    end else if (rv && stall_left > 0) stall_left--;
    if (req_valid && req_ready) begin
      exp_q.push_back(predict(send_q[0], cyc));
      void'(send_q.pop_front());
    end
    @(posedge clk); #1;
    if (pop_m && mem_q.size() > 0) void'(mem_q.pop_front());
    if (push_m) mem_q.push_back(nb);
    drive();
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((send_q.size() > 0 || exp_q.size() > 0) && n < budget) begin cycle(); n++; end
    chk("drained", send_q.size() + exp_q.size(), 0);
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [NB-1:0] em);
    req_t r;
    r.addr = a; r.id = id; r.emask = em;
    send_q.push_back(r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w1;
    int n;
    salt = $urandom;
    rst_n = 0;
    req_addr = '0; req_id = '0; req_valid = 0; rsp_ready = 0;
    mreq_ready = 0; mrsp_data = '0; mrsp_error = 0; mrsp_valid = 0;
    s_addr = '0; s_id = '0; s_valid = 0; s_rready = 0;
    s_mready = 0; s_mdata = '0; s_merror = 0; s_mrvalid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_mreq_valid", mreq_valid, 1'b0);
    chk("reset_mrsp_ready", mrsp_ready, 1'b0);
    chk("reset_rsp_data", rsp_data, '0);
    chk("reset_rsp_id", rsp_id, '0);
    chk("reset_rsp_error", rsp_error, 1'b0);
    chk("reset_1b_req_ready", s_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1;

    // basic refill with exact latency
    lat_check = 1; bp_mode = 0; stall_left = 0;
    send(32'h8000_1234, 2'd2, 4'b0000);
    drive(); run(100);
    // error on beat 2, all beats still stored
    send($urandom, 2'd1, 4'b0100);
    drive(); run(100);
    // memory and response backpressure
    lat_check = 0; bp_mode = 1; stall_left = 5;
    send($urandom, 2'd3, 4'b0000);
    drive(); run(200);
    // back-to-back requests
    bp_mode = 0; stall_left = 0;
    send(32'h0000_1000, 2'd0, 4'b0000);
    send(32'h0000_2018, 2'd1, 4'b0001);
    send(32'h0000_302C, 2'd3, 4'b0000);
    drive(); run(200);
    // randomized traffic
    rand_mode = 1; bp_mode = 2; stall_left = $urandom_range(0, 3);
    for (int i = 0; i < 24; i++)
      send($urandom, 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
    drive(); run(3000);
    rand_mode = 0;

    // reset in the middle of a fetch
    bp_mode = 0; stall_left = 0;
    send(32'h4000_0050, 2'd1, 4'b0000);
    drive();
    n = 0;
    while (recv < 2 && n < 50) begin cycle(); n++; end
    chk("reset_mid_setup_beats", recv, 2);
    rst_n = 0; req_valid = 0; mreq_ready = 0; mrsp_valid = 0;
    mem_q.delete(); exp_q.delete(); send_q.delete();
    issued = 0; recv = 0; hold = 0; seen_v = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("mid_reset_req_ready", req_ready, 1'b1);
    chk("mid_reset_mreq_valid", mreq_valid, 1'b0);
    chk("mid_reset_rsp_valid", rsp_valid, 1'b0);
    chk("mid_reset_mrsp_ready", mrsp_ready, 1'b0);
    @(posedge clk); #1;
    lat_check = 1;
    send(32'hFFFF_FFF8, 2'd2, 4'b1000);
    drive(); run(100);
    lat_check = 0;

    // single-beat instance: response three cycles after accept
    w1 = {$urandom, $urandom};
    s_addr = $urandom; s_id = 2'd1; s_valid = 1; s_mready = 1; s_rready = 1;
    @(negedge clk);
    chk("1b_req_ready", s_ready, 1'b1);
    @(posedge clk); #1;
    s_valid = 0;
    @(negedge clk);
    chk("1b_mreq_valid", s_mvalid, 1'b1);
    chk("1b_mreq_addr", s_maddr, {s_addr[AW-1:3], 3'b000});
    chk("1b_rsp_valid_early1", s_rvalid, 1'b0);
    @(posedge clk); #1;
    s_mrvalid = 1; s_mdata = w1; s_merror = 0;
    @(negedge clk);
    chk("1b_mrsp_ready", s_mrready, 1'b1);
    chk("1b_mreq_done", s_mvalid, 1'b0);
    chk("1b_rsp_valid_early2", s_rvalid, 1'b0);
    @(posedge clk); #1;
    s_mrvalid = 0; s_mdata = '0;
    @(negedge clk);
    chk("1b_rsp_valid", s_rvalid, 1'b1);
    chk("1b_rsp_data", s_rdata, w1);
    chk("1b_rsp_id", s_rid, 2'd1);
    chk("1b_rsp_error", s_rerror, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("1b_back_idle", s_ready, 1'b1);
    chk("1b_rsp_released", s_rvalid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
